// File: rtl/alu_pkg.sv
// Shared ALU result-stage definitions: opcode values and the buffered entry record.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  // result + opcode + {ovf, ne, lt}
  localparam int ENTRY_W = 32 + 5 + 3;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  opcode;
    logic        ovf;
    logic        ne;
    logic        lt;
  } entry_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    return op <= OP_SRA;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generation for one ALU result: signed overflow (add/sub only),
// operand inequality and signed less-than. Zero latency, no flow control.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        result_msb,
  input  logic [4:0]  opcode,
  output logic        ovf,
  output logic        ne,
  output logic        lt
);

  // Overflow only needs the result's sign bit against the operand signs.
  always_comb begin
    ovf = 1'b0;
    case (opcode)
      OP_ADD:  ovf = (op_a[31] == op_b[31]) && (result_msb != op_a[31]);
      OP_SUB:  ovf = (op_a[31] != op_b[31]) && (result_msb != op_a[31]);
      default: ovf = 1'b0;
    endcase
  end

  assign ne = (op_a != op_b);
  assign lt = ($signed(op_a) < $signed(op_b));

endmodule

// File: rtl/alu_result_stage.sv
// DEPTH-entry result buffer with flag capture, saturating overflow counter and sticky illegal-op flag.
// One cycle push-to-out_valid; in_ready is registered not-full, independent of out_ready.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic [4:0]       in_opcode,
  input  logic [31:0]      in_opA,
  input  logic [31:0]      in_opB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_opcode,
  output logic             out_ovf,
  output logic             out_ne,
  output logic             out_lt,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clear,
  output logic             illegal_op
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             live;
  logic             push;
  logic             pop;
  logic             f_ovf;
  logic             f_ne;
  logic             f_lt;

  alu_flag_gen u_flag_gen (
    .op_a       (in_opA),
    .op_b       (in_opB),
    .result_msb (in_result[31]),
    .opcode     (in_opcode),
    .ovf        (f_ovf),
    .ne         (f_ne),
    .lt         (f_lt)
  );

  assign new_entry = '{result: in_result, opcode: in_opcode, ovf: f_ovf, ne: f_ne, lt: f_lt};

  // live holds in_ready low until the first edge after reset is released.
  assign in_ready  = live && (occ != FULL_OCC);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head       = mem[rd_ptr];
  assign out_result = head.result;
  assign out_opcode = head.opcode;
  assign out_ovf    = head.ovf;
  assign out_ne     = head.ne;
  assign out_lt     = head.lt;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // A clear coinciding with an overflow push counts that push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= (push && f_ovf) ? CNT_W'(1) : '0;
    end else if (push && f_ovf && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal_op <= 1'b0;
    end else if (push && !is_legal_op(in_opcode)) begin
      illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: randomized and directed pushes against an arithmetic reference model.
module tb_alu_result_stage;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic [4:0]       in_opcode;
  logic [31:0]      in_opA;
  logic [31:0]      in_opB;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [4:0]       out_opcode;
  logic             out_ovf;
  logic             out_ne;
  logic             out_lt;
  logic [CNT_W-1:0] ovf_count;
  logic             ovf_clear;
  logic             illegal_op;

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_opcode  (in_opcode),
    .in_opA     (in_opA),
    .in_opB     (in_opB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .out_ovf    (out_ovf),
    .out_ne     (out_ne),
    .out_lt     (out_lt),
    .ovf_count  (ovf_count),
    .ovf_clear  (ovf_clear),
    .illegal_op (illegal_op)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  op;
    logic        ovf;
    logic        ne;
    logic        lt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   n_popped = 0;
  int   m_cnt    = 0;
  bit   m_ill    = 1'b0;
  bit   rdy_mode = 1'b0;
  bit   rdy_force = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: what the upstream opcode mux would present.
  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << b[4:0];
      5'd5:    return $unsigned($signed(a) >>> b[4:0]);
      default: return $urandom;
    endcase
  endfunction

  // Overflow judged on the true mathematical result, not on sign bits.
  function automatic exp_t predict(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] res);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = (op == 5'd0) ? sa + sb : sa - sb;
    e.res = res;
    e.op  = op;
    e.ne  = (a != b);
    e.lt  = (sa < sb);
    e.ovf = (op <= 5'd1) && ((r > 64'sd2147483647) || (r < -64'sd2147483648));
    return e;
  endfunction

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit clr,
                      input int max_wait, output bit acc);
    exp_t        e;
    logic [31:0] res;
    res = alu_ref(op, a, b);
    e   = predict(op, a, b, res);
    in_valid = 1'b1; in_opcode = op; in_opA = a; in_opB = b; in_result = res; ovf_clear = clr;
    acc = 1'b0;
    for (int w = 0; w <= max_wait && !acc; w++) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1'b1;
        q.push_back(e);
        if (clr) m_cnt = e.ovf ? 1 : 0;
        else if (e.ovf && m_cnt != CNT_MAX) m_cnt++;
        if (op > 5'd5) m_ill = 1'b1;
      end else if (clr) begin
        m_cnt = 0;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    ovf_clear = 1'b0;
  endtask

  task automatic send_ok(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit clr);
    bit acc;
    send(op, a, b, clr, 50, acc);
    chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic status();
    chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
    chk("illegal_op", 64'(illegal_op), 64'(m_ill));
  endtask

  function automatic logic [31:0] rand_operand(input logic [31:0] other);
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h7FFF_FFFF - $urandom_range(0, 3);
      2:       return 32'h8000_0000 + $urandom_range(0, 3);
      default: return other;
    endcase
  endfunction

  always @(posedge clock) begin
    #1;
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: compares the head every cycle it is valid, held or taken.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        chk("out_result", 64'(out_result), 64'(q[0].res));
        chk("out_opcode", 64'(out_opcode), 64'(q[0].op));
        chk("out_ovf", 64'(out_ovf), 64'(q[0].ovf));
        chk("out_ne", 64'(out_ne), 64'(q[0].ne));
        chk("out_lt", 64'(out_lt), 64'(q[0].lt));
        if (out_ready) begin
          void'(q.pop_front());
          n_popped++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int pop_base;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int r;

    reset_n = 1'b0; in_valid = 1'b0; in_result = '0; in_opcode = '0;
    in_opA = '0; in_opB = '0; ovf_clear = 1'b0;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_ovf_count", 64'(ovf_count), 64'd0);
    chk("reset_illegal_op", 64'(illegal_op), 64'd0);
    chk("reset_out_data", {out_result, out_opcode, out_ovf, out_ne, out_lt}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    cyc(1);
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Signed overflow on add, then sub, then a logic op that must not count.
    rdy_force = 1'b1;
    send_ok(5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("out_valid_next_cycle", 64'(out_valid), 64'd1);
    chk("ovf_count_add", 64'(ovf_count), 64'd1);
    send_ok(5'd1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    chk("ovf_count_sub", 64'(ovf_count), 64'd2);
    send_ok(5'd2, 32'h8000_0000, 32'h0000_0001, 1'b0);
    chk("ovf_count_and", 64'(ovf_count), 64'd2);
    status();

    // Fill with downstream stalled, refuse a third, then drain in order.
    cyc(2);
    rdy_force = 1'b0;
    cyc(2);
    send_ok(5'd3, 32'h1234_0000, 32'h0000_5678, 1'b0);
    send_ok(5'd4, 32'h0000_00FF, 32'h0000_0004, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    send(5'd5, 32'hF000_0000, 32'h0000_0002, 1'b0, 0, acc);
    chk("third_push_refused", 64'(acc), 64'd0);
    pop_base = n_popped;
    rdy_force = 1'b1;
    cyc(5);
    chk("drain_count", 64'(n_popped - pop_base), 64'd2);
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Streaming: one entry per cycle with pointer wrap.
    pop_base = n_popped;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      send(5'($urandom_range(0, 5)), a, b, 1'b0, 0, acc);
      chk("stream_accept", 64'(acc), 64'd1);
    end
    cyc(3);
    chk("stream_count", 64'(n_popped - pop_base), 64'd10);
    chk("stream_empty", 64'(q.size()), 64'd0);

    // Counter saturation, clear-with-overflow, sticky illegal opcode.
    send_ok(5'd0, 32'h7FFF_FFFF, 32'($urandom_range(1, 1000)), 1'b1);
    chk("clear_then_one", 64'(ovf_count), 64'd1);
    for (int i = 0; i < 16; i++) send_ok(5'd0, 32'h7FFF_FFFF, 32'($urandom_range(1, 1000)), 1'b0);
    chk("ovf_saturated", 64'(ovf_count), 64'hF);
    send_ok(5'd1, 32'h8000_0000, 32'($urandom_range(1, 1000)), 1'b1);
    chk("clear_with_ovf", 64'(ovf_count), 64'd1);
    chk("illegal_before", 64'(illegal_op), 64'd0);
    send_ok(5'd7, 32'h0000_0003, 32'h0000_0003, 1'b0);
    chk("illegal_set", 64'(illegal_op), 64'd1);
    send_ok(5'd0, 32'h0000_0001, 32'h0000_0002, 1'b0);
    chk("illegal_held", 64'(illegal_op), 64'd1);
    status();

    // Random traffic with random backpressure.
    rdy_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 8) ? 5'(r % 6) : 5'($urandom_range(6, 31));
      a  = rand_operand($urandom);
      b  = rand_operand(a);
      send_ok(op, a, b, $urandom_range(0, 19) == 0);
    end
    status();
    rdy_mode = 1'b0;
    rdy_force = 1'b1;
    cyc(6);
    chk("random_drained", 64'(q.size()), 64'd0);

    // Asynchronous reset with two entries buffered.
    rdy_force = 1'b0;
    cyc(2);
    send_ok(5'd0, 32'h7FFF_FFFF, 32'h0000_0010, 1'b0);
    send_ok(5'd3, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    chk("prereset_full", 64'(out_valid && !in_ready), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_ovf_count", 64'(ovf_count), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_illegal_op", 64'(illegal_op), 64'd0);
    chk("async_out_result", 64'(out_result), 64'd0);
    q.delete();
    m_cnt = 0;
    m_ill = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    rdy_force = 1'b1;
    cyc(2);
    send_ok(5'd1, 32'h0000_0005, 32'h0000_0009, 1'b0);
    cyc(4);
    chk("post_reset_empty", 64'(q.size()), 64'd0);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    status();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DEPTH, default 2, number of result-buffer entries; legal values 2 and 4 only.
REQ-002 Parameter CNT_W, default 16, width of the overflow event counter.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream presents a selected ALU result.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  32  result chosen by the opcode mux.
REQ-008 in_opcode  input  5  ALU opcode of that result.
REQ-009 in_opA, in_opB  input  32 each  operands that produced in_result.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_result  output  32  buffered result.
REQ-013 out_opcode  output  5  buffered opcode.
REQ-014 out_ovf, out_ne, out_lt  output  1 each  buffered overflow, not-equal and signed less-than flags.
REQ-015 ovf_count  output  CNT_W  saturating count of accepted overflow entries.
REQ-016 ovf_clear  input  1  synchronous clear of ovf_count.
REQ-017 illegal_op  output  1  sticky; set on acceptance of an opcode outside 0-5.

Function
REQ-018 Opcode map: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra.
REQ-019 Push: in_valid && in_ready at the edge; pop: out_valid && out_ready at the edge.
REQ-020 in_ready SHALL equal not-full and depend only on registered state, with no combinational path from out_ready.
REQ-021 Outputs out_* SHALL be driven from the head register only, giving one cycle minimum latency from push to out_valid.
REQ-022 Entries SHALL leave in push order; out_* SHALL stay stable while out_valid && !out_ready.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged, including when full (in_ready already low, so no push) and when empty (no pop).
REQ-024 Read/write pointers SHALL wrap modulo DEPTH.
REQ-025 Overflow for add: opA[31]==opB[31] and result[31]!=opA[31].
REQ-026 Overflow for sub: opA[31]!=opB[31] and result[31]!=opA[31].
REQ-027 Overflow SHALL be 0 for every other opcode.
REQ-028 ne = (opA != opB); lt = signed opA < opB.
REQ-029 ne and lt SHALL be computed for every opcode and sampled at push.
REQ-030 ovf_count SHALL increment on each push with overflow=1 and saturate at all-ones.
REQ-031 When ovf_clear and an overflow push coincide, ovf_count SHALL become 1.
REQ-032 Opcodes 6-31 SHALL still be buffered, with ovf=0, and SHALL set illegal_op.
REQ-033 illegal_op SHALL clear only on reset.

Reset
REQ-034 reset_n low SHALL asynchronously empty the buffer and zero the pointers.
REQ-035 During reset: out_valid=0, in_ready=0, ovf_count=0, illegal_op=0, out_result/out_opcode/flags=0.
REQ-036 in_ready SHALL rise on the first edge after reset_n deasserts.
REQ-037 Reset mid-transfer SHALL discard all buffered entries; no partial entry survives.

Structure
REQ-038 Shared package alu_pkg SHALL hold the opcode constants, the entry width (32+5+3) and the entry record type.
REQ-039 Flag logic SHALL be a combinational sub-module alu_flag_gen (operands, result, opcode -> ovf, ne, lt).
REQ-040 Buffer storage and pointers SHALL live in alu_result_stage.

Verification
REQ-041 Add 0x7FFFFFFF+0x00000001, result 0x80000000, opcode 0 -> next cycle out_valid=1, out_ovf=1, out_ne=1, out_lt=0, ovf_count=1.
REQ-042 Sub 0x80000000-0x00000001, result 0x7FFFFFFF, opcode 1 -> out_ovf=1, out_lt=1; same operands with opcode 2 -> out_ovf=0, ovf_count unchanged.
REQ-043 Hold out_ready=0 and push 2 entries -> in_ready=0; third in_valid is not accepted; raising out_ready drains entries in order A then B.
REQ-044 Continuous in_valid/out_ready=1 for 10 entries -> one entry per cycle, correct order, pointers wrap, no loss.
REQ-045 Preload ovf_count to all-ones via overflow pushes (CNT_W override 4) -> stays 0xF; ovf_clear together with an overflow push -> 1; opcode 7 -> illegal_op=1, held.
REQ-046 Assert reset_n=0 with 2 entries buffered -> out_valid=0 and ovf_count=0 immediately, without a clock edge.
